// File: rtl/us_ip_pkg.sv
// Shared IP transmit definitions: protocol numbers, arbiter state encoding and
// the skid-buffer payload width helper.
package us_ip_pkg;

  localparam logic [7:0] IP_PROTO_ICMP = 8'h01;
  localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // tdata + tkeep + tlast + protocol + channel index
  function automatic int tx_pld_w(input int data_w, input int num_ch);
    return data_w + data_w / 8 + 1 + 8 + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/us_axis_skid_buf.sv
// Two-entry AXI-stream skid buffer: registered output stage plus one overflow
// slot, so in_ready depends only on local state.
module us_axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         tx_axis_aclk,
  input  logic         tx_axis_aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_vld;
  logic [W-1:0] skid_data;

  assign in_ready = ~skid_vld;

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (out_ready || !out_valid) begin
      // output stage free: refill from the overflow slot first to keep order
      if (skid_vld) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        skid_vld  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_vld) begin
      skid_vld  <= 1'b1;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/us_ip_tx_arbiter.sv
// Packet-level arbiter merging NUM_CH upstream AXI streams onto one IP tx stream.
// Define US_IP_TX_RR_EN for round-robin arbitration; default is fixed priority.
module us_ip_tx_arbiter
  import us_ip_pkg::*;
#(
  parameter int                    NUM_CH   = 2,
  parameter int                    DATA_W   = 64,
  parameter logic [NUM_CH*8-1:0]   CH_PROTO = {IP_PROTO_ICMP, IP_PROTO_UDP}
) (
  input  logic                          tx_axis_aclk,
  input  logic                          tx_axis_aresetn,
  input  logic [NUM_CH*DATA_W-1:0]      ch_tx_axis_tdata,
  input  logic [NUM_CH*DATA_W/8-1:0]    ch_tx_axis_tkeep,
  input  logic [NUM_CH-1:0]             ch_tx_axis_tvalid,
  input  logic [NUM_CH-1:0]             ch_tx_axis_tlast,
  output logic [NUM_CH-1:0]             ch_tx_axis_tready,
  output logic [DATA_W-1:0]             ip_tx_axis_tdata,
  output logic [DATA_W/8-1:0]           ip_tx_axis_tkeep,
  output logic                          ip_tx_axis_tvalid,
  output logic                          ip_tx_axis_tlast,
  input  logic                          ip_tx_axis_tready,
  output logic [7:0]                    ip_send_type,
  output logic [$clog2(NUM_CH)-1:0]     ip_send_ch
);

  localparam int TKW = DATA_W / 8;
  localparam int CW  = $clog2(NUM_CH);
  localparam int PW  = tx_pld_w(DATA_W, NUM_CH);

  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0][TKW-1:0]    ch_keep;
  logic [NUM_CH-1:0][7:0]        ch_proto;

  assign ch_data  = ch_tx_axis_tdata;
  assign ch_keep  = ch_tx_axis_tkeep;
  assign ch_proto = CH_PROTO;

  arb_state_e    state, state_nxt;
  logic [CW-1:0] grant, grant_nxt, pick;
  logic          found;
  logic [CW-1:0] idx;
  logic          sk_in_valid, sk_in_ready, beat_acc;
  logic [PW-1:0] sk_in_data, sk_out_data;

`ifdef US_IP_TX_RR_EN
  logic [CW-1:0] rr_ptr, rr_ptr_nxt;
`endif

  // request search: fixed priority from 0, or round-robin from the pointer
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef US_IP_TX_RR_EN
      idx = CW'((int'(rr_ptr) + i) % NUM_CH);
`else
      idx = CW'(i);
`endif
      if (!found && ch_tx_axis_tvalid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sk_in_valid = (state == ST_XFER) && ch_tx_axis_tvalid[grant];
  assign beat_acc    = sk_in_valid && sk_in_ready;
  assign sk_in_data  = {ch_data[grant], ch_keep[grant], ch_tx_axis_tlast[grant],
                        ch_proto[grant], grant};

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
`ifdef US_IP_TX_RR_EN
    rr_ptr_nxt = rr_ptr;
`endif
    case (state)
      ST_IDLE: begin
        if (|ch_tx_axis_tvalid) begin
          grant_nxt = pick;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat_acc && ch_tx_axis_tlast[grant]) begin
          state_nxt = ST_IDLE;
`ifdef US_IP_TX_RR_EN
          rr_ptr_nxt = (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state <= ST_IDLE;
      grant <= '0;
`ifdef US_IP_TX_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
`ifdef US_IP_TX_RR_EN
      rr_ptr <= rr_ptr_nxt;
`endif
    end
  end

  // ready comes from registered state only, never from ip_tx_axis_tready
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rdy
    assign ch_tx_axis_tready[gi] = (state == ST_XFER) && (grant == CW'(gi)) && sk_in_ready;
  end

  us_axis_skid_buf #(.W(PW)) u_skid (
    .tx_axis_aclk    (tx_axis_aclk),
    .tx_axis_aresetn (tx_axis_aresetn),
    .in_valid        (sk_in_valid),
    .in_ready        (sk_in_ready),
    .in_data         (sk_in_data),
    .out_valid       (ip_tx_axis_tvalid),
    .out_ready       (ip_tx_axis_tready),
    .out_data        (sk_out_data)
  );

  assign {ip_tx_axis_tdata, ip_tx_axis_tkeep, ip_tx_axis_tlast, ip_send_type, ip_send_ch} = sk_out_data;

endmodule
